// File: rtl/lcd_frame_arbiter.sv
// Round-robin, per-frame arbiter sharing one LCD driver between two character sources.
// Define LCD_ARB_TIMEOUT_EN to enable the per-frame watchdog that aborts a frame the driver never finishes.
module lcd_frame_arbiter #(
    parameter int          TIMEOUT_TICKS = 64,
    parameter logic [7:0]  IDLE_CHAR     = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_clk,
    input  logic [1:0] req,
    output logic [1:0] ack,
    output logic [1:0] grant,
    output logic [4:0] char_index,
    input  logic [7:0] src0_char,
    input  logic [7:0] src1_char,
    input  logic [4:0] drv_index,
    output logic [7:0] drv_data,
    output logic       drv_start,
    input  logic       drv_done,
    output logic       err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ACK} state_t;

    state_t     r_state;
    logic       r_last;
    logic       r_winner;
    logic [1:0] r_grant;
    logic [1:0] r_ack;
    logic       r_start;
    logic       w_pick;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam logic [8:0] TO_LIM = 9'(TIMEOUT_TICKS);
    logic [7:0] r_wdog;
    logic       r_err;
    logic       w_expire;
    // Expiry is judged on the count this tick would produce, so grant drops on the Nth tick itself.
    assign w_expire = en_clk && (({1'b0, r_wdog} + 9'd1) >= TO_LIM);
    assign err      = r_err;
`else
    logic w_unused;
    assign w_unused = en_clk | (TIMEOUT_TICKS == 0);
    assign err      = 1'b0;
`endif

    // Contention goes to the source that was not served last.
    always_comb begin
        w_pick = 1'b0;
        case (req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            default: w_pick = ~r_last;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_winner <= 1'b0;
            r_grant  <= 2'b00;
            r_ack    <= 2'b00;
            r_start  <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            r_wdog   <= 8'd0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_ack   <= 2'b00;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_winner <= w_pick;
                        r_grant  <= w_pick ? 2'b10 : 2'b01;
                        r_start  <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
`ifdef LCD_ARB_TIMEOUT_EN
                    r_wdog  <= 8'd0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // drv_done takes priority over a coincident watchdog expiry.
                    if (drv_done) begin
                        r_ack   <= r_grant;
                        r_grant <= 2'b00;
                        r_last  <= r_winner;
                        r_state <= S_ACK;
                    end
`ifdef LCD_ARB_TIMEOUT_EN
                    else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_grant <= 2'b00;
                        r_last  <= r_winner;
                        r_state <= S_IDLE;
                    end else if (en_clk) begin
                        r_wdog  <= r_wdog + 8'd1;
                    end
`endif
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack        = r_ack;
    assign grant      = r_grant;
    assign drv_start  = r_start;
    assign char_index = drv_index;

    always_comb begin
        case (r_grant)
            2'b01:   drv_data = src0_char;
            2'b10:   drv_data = src1_char;
            default: drv_data = IDLE_CHAR;
        endcase
    end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Bench for lcd_frame_arbiter: table of frame requests with expected grants, ack scoreboard,
// and hand sequences for idle drv_done, mid-frame reset and (when enabled) watchdog abort.
module tb_lcd_frame_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_clk = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] ack;
    logic [1:0] grant;
    logic [4:0] char_index;
    logic [7:0] src0_char = 8'h00;
    logic [7:0] src1_char = 8'h00;
    logic [4:0] drv_index = 5'd0;
    logic [7:0] drv_data;
    logic       drv_start;
    logic       drv_done = 1'b0;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [1:0] ack_q[$];

    lcd_frame_arbiter #(.TIMEOUT_TICKS(4), .IDLE_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .en_clk(en_clk), .req(req), .ack(ack), .grant(grant),
        .char_index(char_index), .src0_char(src0_char), .src1_char(src1_char),
        .drv_index(drv_index), .drv_data(drv_data), .drv_start(drv_start),
        .drv_done(drv_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack pulse must match the next expected frame owner.
    always @(negedge clk) begin
        if (rst && ack != 2'b00) begin
            if (ack_q.size() == 0) chk("unexpected_ack", {30'd0, ack}, 32'd0);
            else                   chk("ack_value", {30'd0, ack}, {30'd0, ack_q.pop_front()});
        end
    end

    task automatic start_frame(input logic [1:0] r, input logic [1:0] exp);
        bit ok;
        ok  = 1'b0;
        req = r;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grant != 2'b00) begin ok = 1'b1; break; end
        end
        chk("grant_wait", {31'd0, ok}, 32'd1);
        chk("grant", {30'd0, grant}, {30'd0, exp});
        chk("drv_start_hi", {31'd0, drv_start}, 32'd1);
        @(negedge clk);
        chk("drv_start_lo", {31'd0, drv_start}, 32'd0);
    endtask

    task automatic finish_frame(input int dly, input logic [1:0] exp);
        ack_q.push_back(exp);
        repeat (dly) @(negedge clk);
        chk("grant_held", {30'd0, grant}, {30'd0, exp});
        drv_done = 1'b1;
        @(negedge clk);
        drv_done = 1'b0;
        chk("ack_present", {31'd0, (ack != 2'b00)}, 32'd1);
        chk("grant_cleared", {30'd0, grant}, 32'd0);
        chk("idle_char", {24'd0, drv_data}, 32'h20);
        req = 2'b00;
        @(negedge clk);
        chk("ack_one_cycle", {30'd0, ack}, 32'd0);
    endtask

    typedef struct {
        logic [1:0] req;
        int         dly;
        bit         drop;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{2'b01, 5,  1'b0, 2'b01};
        vecs[1] = '{2'b10, 3,  1'b0, 2'b10};
        vecs[2] = '{2'b11, 40, 1'b0, 2'b01};
        vecs[3] = '{2'b11, 40, 1'b0, 2'b10};
        vecs[4] = '{2'b11, 40, 1'b0, 2'b01};
        vecs[5] = '{2'b11, 40, 1'b0, 2'b10};
        vecs[6] = '{2'b01, 6,  1'b1, 2'b01};
        vecs[7] = '{2'b10, 4,  1'b0, 2'b10};
        vecs[8] = '{2'b01, 4,  1'b0, 2'b01};

        #1;
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_start", {31'd0, drv_start}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_idle_char", {24'd0, drv_data}, 32'h20);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            src0_char = 8'h30 + 8'(i);
            src1_char = 8'h40 + 8'(i);
            drv_index = 5'(i + 6);
            start_frame(vecs[i].req, vecs[i].exp_grant);
            if (vecs[i].drop) req = 2'b00;
            chk("drv_data", {24'd0, drv_data},
                {24'd0, (vecs[i].exp_grant == 2'b01) ? src0_char : src1_char});
            chk("char_index", {27'd0, char_index}, {27'd0, drv_index});
            finish_frame(vecs[i].dly, vecs[i].exp_grant);
        end

        // drv_done while idle must not start or acknowledge anything.
        drv_done = 1'b1;
        @(negedge clk);
        drv_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("idle_done_grant", {30'd0, grant}, 32'd0);
            chk("idle_done_start", {31'd0, drv_start}, 32'd0);
            @(negedge clk);
        end

        // Reset mid-frame: the in-flight grant to source 1 is dropped, then source 0 wins.
        start_frame(2'b11, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_grant", {30'd0, grant}, 32'd0);
        chk("midrst_start", {31'd0, drv_start}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_ack", {30'd0, ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        start_frame(2'b11, 2'b01);
        finish_frame(5, 2'b01);

`ifdef LCD_ARB_TIMEOUT_EN
        start_frame(2'b11, 2'b10);
        for (int p = 0; p < 4; p++) begin
            en_clk = 1'b1;
            @(negedge clk);
            en_clk = 1'b0;
            if (p < 3) begin
                chk("wdog_hold_grant", {30'd0, grant}, 32'd2);
                chk("wdog_hold_err", {31'd0, err}, 32'd0);
            end
        end
        chk("wdog_grant_clr", {30'd0, grant}, 32'd0);
        chk("wdog_err_set", {31'd0, err}, 32'd1);
        @(negedge clk);
        chk("wdog_next_grant", {30'd0, grant}, 32'd1);
        @(negedge clk);
        finish_frame(4, 2'b01);
        chk("wdog_err_sticky", {31'd0, err}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", ack_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
